// File: rtl/tick_scheduler_if.sv
// Signal bundle between the stopwatch timebase and its surroundings.
// The slave side is the scheduler; the master side drives the switch inputs.
interface tick_scheduler_if;
    logic i_adj;
    logic i_pause;
    logic o_tick_2hz;
    logic o_tick_1hz;
    logic o_sel_tick;
    logic o_tick_refresh;
    logic o_blink;
    logic o_adj_mode;

    modport master (
        output i_adj,
        output i_pause,
        input  o_tick_2hz,
        input  o_tick_1hz,
        input  o_sel_tick,
        input  o_tick_refresh,
        input  o_blink,
        input  o_adj_mode
    );

    modport slave (
        input  i_adj,
        input  i_pause,
        output o_tick_2hz,
        output o_tick_1hz,
        output o_sel_tick,
        output o_tick_refresh,
        output o_blink,
        output o_adj_mode
    );
endinterface

// File: rtl/tick_scheduler.sv
// Stopwatch timebase: 2 Hz / 1 Hz / refresh clock-enable pulses plus a
// count enable whose rate switches between 1 Hz and 2 Hz only on 2 Hz ticks.
module tick_scheduler #(
    parameter int DIV_2HZ     = 50_000_000,
    parameter int DIV_REFRESH = 200_000
) (
    input  logic             clk,
    input  logic             rst,
    tick_scheduler_if.slave  bus
);
    localparam int W2 = (DIV_2HZ > 1) ? $clog2(DIV_2HZ) : 1;
    localparam int WR = (DIV_REFRESH > 1) ? $clog2(DIV_REFRESH) : 1;

    typedef enum logic {NORMAL = 1'b0, ADJUST = 1'b1} modeState_t;

    logic          r_adjMeta, r_adjS;
    logic          r_pauseMeta, r_pauseS;
    logic [W2-1:0] r_cnt2;
    logic [WR-1:0] r_cntr;
    logic          r_phase;
    logic          r_tick2hz, r_tick1hz, r_selTick, r_tickRefresh;
    modeState_t    r_state, w_nextState;
    logic          w_wrap2, w_wrapR, w_adjMode;

    assign w_wrap2 = (r_cnt2 == W2'(DIV_2HZ - 1));
    assign w_wrapR = (r_cntr == WR'(DIV_REFRESH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_adjMeta   <= 1'b0;
            r_adjS      <= 1'b0;
            r_pauseMeta <= 1'b0;
            r_pauseS    <= 1'b0;
        end else begin
            r_adjMeta   <= bus.i_adj;
            r_adjS      <= r_adjMeta;
            r_pauseMeta <= bus.i_pause;
            r_pauseS    <= r_pauseMeta;
        end
    end

    // sel_tick uses the mode and phase from before this edge's update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt2    <= '0;
            r_phase   <= 1'b0;
            r_tick2hz <= 1'b0;
            r_tick1hz <= 1'b0;
            r_selTick <= 1'b0;
        end else if (w_wrap2) begin
            r_cnt2    <= '0;
            r_phase   <= ~r_phase;
            r_tick2hz <= 1'b1;
            r_tick1hz <= r_phase;
            r_selTick <= ~r_pauseS & (w_adjMode | r_phase);
        end else begin
            r_cnt2    <= r_cnt2 + 1'b1;
            r_tick2hz <= 1'b0;
            r_tick1hz <= 1'b0;
            r_selTick <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cntr        <= '0;
            r_tickRefresh <= 1'b0;
        end else if (w_wrapR) begin
            r_cntr        <= '0;
            r_tickRefresh <= 1'b1;
        end else begin
            r_cntr        <= r_cntr + 1'b1;
            r_tickRefresh <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= NORMAL;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Mode is only resampled on 2 Hz tick edges
    always_comb begin
        w_nextState = r_state;
        if (w_wrap2) begin
            w_nextState = r_adjS ? ADJUST : NORMAL;
        end
    end

    always_comb begin
        w_adjMode = (r_state == ADJUST);
    end

    assign bus.o_tick_2hz     = r_tick2hz;
    assign bus.o_tick_1hz     = r_tick1hz;
    assign bus.o_sel_tick     = r_selTick;
    assign bus.o_tick_refresh = r_tickRefresh;
    assign bus.o_blink        = r_phase;
    assign bus.o_adj_mode     = w_adjMode;
endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler with DIV_2HZ=10, DIV_REFRESH=4; edges
// are numbered from reset release and outputs are sampled 1 ns after each edge.
module tb_tick_scheduler;
    logic clk;
    logic rst;
    int   edgeNum;
    int   passCount;
    int   checkCount;

    tick_scheduler_if bus ();

    tick_scheduler #(
        .DIV_2HZ     (10),
        .DIV_REFRESH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic adjV, input logic pauseV);
        bus.i_adj   = adjV;
        bus.i_pause = pauseV;
    endtask

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s at edge %0d: observed %b expected %b",
                    tag, edgeNum, observed, expected);
    endtask

    task automatic checkAll(input logic e2, input logic e1, input logic eSel,
                            input logic eRef, input logic eBlink, input logic eMode);
        checkOutput("tick_2hz",     bus.o_tick_2hz,     e2);
        checkOutput("tick_1hz",     bus.o_tick_1hz,     e1);
        checkOutput("sel_tick",     bus.o_sel_tick,     eSel);
        checkOutput("tick_refresh", bus.o_tick_refresh, eRef);
        checkOutput("blink",        bus.o_blink,        eBlink);
        checkOutput("adj_mode",     bus.o_adj_mode,     eMode);
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
        edgeNum++;
    endtask

    // Hold reset for a few cycles, check the reset state, release between edges
    task automatic doReset(input logic adjV, input logic pauseV);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(adjV, pauseV);
        repeat (3) @(posedge clk);
        @(negedge clk);
        edgeNum = 0;
        checkAll(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        edgeNum    = 0;
        rst        = 1'b1;
        applyStimulus(0, 0);

        $display("[TB] basic timing, adj=0 pause=0");
        doReset(0, 0);
        for (int e = 1; e <= 45; e++) begin
            stepEdge();
            checkAll(e % 10 == 0, e % 20 == 0, e % 20 == 0, e % 4 == 0,
                     (e / 10) % 2 == 1, 0);
        end

        $display("[TB] adjust raised at 12, lowered at 52");
        doReset(0, 0);
        for (int e = 1; e <= 85; e++) begin
            stepEdge();
            checkAll(e % 10 == 0, e % 20 == 0,
                     (e == 20 || e == 30 || e == 40 || e == 50 || e == 60 || e == 80),
                     e % 4 == 0, (e / 10) % 2 == 1, (e >= 20 && e < 60));
            if (e == 12) applyStimulus(1, 0);
            if (e == 52) applyStimulus(0, 0);
        end

        $display("[TB] adj glitch between ticks");
        doReset(0, 0);
        for (int e = 1; e <= 45; e++) begin
            stepEdge();
            checkAll(e % 10 == 0, e % 20 == 0, e % 20 == 0, e % 4 == 0,
                     (e / 10) % 2 == 1, 0);
            if (e == 12) applyStimulus(1, 0);
            if (e == 15) applyStimulus(0, 0);
        end

        $display("[TB] pause from 15 to 45");
        doReset(0, 0);
        for (int e = 1; e <= 65; e++) begin
            stepEdge();
            checkAll(e % 10 == 0, e % 20 == 0, e == 60, e % 4 == 0,
                     (e / 10) % 2 == 1, 0);
            if (e == 15) applyStimulus(0, 1);
            if (e == 45) applyStimulus(0, 0);
        end

        $display("[TB] asynchronous reset mid-period");
        doReset(1, 0);
        for (int e = 1; e <= 23; e++) begin
            stepEdge();
            checkAll(e % 10 == 0, e == 20, e == 20, e % 4 == 0,
                     (e / 10) % 2 == 1, e >= 10);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkAll(0, 0, 0, 0, 0, 0);
        for (int e = 24; e <= 30; e++) begin
            stepEdge();
            checkAll(0, 0, 0, 0, 0, 0);
        end
        @(negedge clk);
        rst = 1'b0;
        edgeNum = 0;
        for (int e = 1; e <= 12; e++) begin
            stepEdge();
            checkAll(e == 10, 0, 0, e % 4 == 0, e >= 10, e >= 10);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Single-clock timebase controller for the stopwatch datapath. Divides the board clock into one-cycle clock-enable pulses at 2 Hz, 1 Hz and display-refresh rate. Produces `sel_tick`, the count enable for the stopwatch counters: 1 Hz in normal mode, 2 Hz in adjust mode. Adjust-mode switchover happens only on 2 Hz tick boundaries, so no tick is dropped or doubled, and the downstream logic never runs on a muxed clock.

## Interface
- `DIV_2HZ`, default 50_000_000: clk cycles per 2 Hz tick period; must be ≥ 4.
- `DIV_REFRESH`, default 200_000: clk cycles per refresh tick period; must be ≥ 2.
- `clk`  in  1  board clock, 100 MHz; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset; clears all state immediately.
- `adj`  in  1  adjust-mode request, asynchronous level (switch).
- `pause`  in  1  pause request, asynchronous level (debounced latch).
- `tick_2hz`  out  1  one-cycle pulse every `DIV_2HZ` cycles.
- `tick_1hz`  out  1  one-cycle pulse on every second `tick_2hz`.
- `sel_tick`  out  1  one-cycle count enable for the stopwatch counters.
- `tick_refresh`  out  1  one-cycle pulse every `DIV_REFRESH` cycles.
- `blink`  out  1  50 % square wave, toggles on every `tick_2hz`.
- `adj_mode`  out  1  currently applied mode: 1 = adjust, 0 = normal.

## Operation
- `adj` and `pause` each pass through a 2-flop synchronizer, giving `adj_s` and `pause_s`. Both synchronizers reset to 0.
- **2 Hz counter `cnt2`** (width ceil(log2(DIV_2HZ))):
  - Counts 0..DIV_2HZ-1.
  - On the edge where `cnt2`==DIV_2HZ-1, it does all of the following together:
    - `cnt2`←0
    - `tick_2hz`←1
    - `phase`←~`phase`
    - `tick_1hz`←`phase`, using the pre-toggle value
    - `adj_mode`←`adj_s`
    - `sel_tick`←~`pause_s` & (`adj_mode` ? 1 : `phase`), using the pre-update `adj_mode` and `phase`
  - On every other edge: `cnt2`←`cnt2`+1, and all three tick outputs ←0.
- `blink` = `phase` (registered).
- **Refresh counter `cntr`**:
  - Independent of `cnt2`; counts 0..DIV_REFRESH-1.
  - `tick_refresh`←1 on the wrap edge, otherwise 0.
  - Unaffected by `adj` and `pause`.
- **Mode state machine**, two states:
  - States: NORMAL (`adj_mode`=0) and ADJUST (`adj_mode`=1).
  - Transitions are evaluated only on `tick_2hz` edges; `adj_s` is ignored between ticks.
  - The tick edge that changes `adj_mode` uses the old mode for that cycle's `sel_tick`.
- **Pause**:
  - Gates only `sel_tick`. Dividers, `phase`, `blink` and mode updates continue.
  - A paused tick is dropped, not deferred.
- **Simultaneous events**: `adj` and `pause` changing on the same tick edge are both applied on that edge as described; neither takes priority.
- **Counters**: no saturation; both always wrap. Reset mid-count discards the partial period.

## Timing
- Reset values while `rst`=1 (asynchronous):
  - All outputs 0: `tick_2hz`, `tick_1hz`, `sel_tick`, `tick_refresh`, `blink`, `adj_mode`.
  - `cnt2`=0, `cntr`=0, `phase`=0, both synchronizers 0.
- After reset release, counting from the first rising edge as edge 1:
  - `tick_2hz` high in the cycle after edge DIV_2HZ, then every DIV_2HZ cycles.
  - `tick_1hz` on the 2nd, 4th, … `tick_2hz`.
- Tick outputs are high for exactly one clk cycle and are never high on two consecutive cycles.
- `tick_1hz` is always coincident with a `tick_2hz`.
- `sel_tick` is always coincident with `tick_2hz`, and never asserts outside a `tick_2hz` cycle.
- Control latency: a change on `adj`/`pause` is visible in `adj_s`/`pause_s` after 2 edges. It takes effect on the first `tick_2hz` edge after that.
- Glitch rule: an `adj`/`pause` pulse that starts and ends between two tick edges has no effect.

## Test plan
Bench parameters: DIV_2HZ=10, DIV_REFRESH=4. Edges are counted from reset release.
- **Reset release, adj=0, pause=0** -> `tick_2hz` at edges 10, 20, 30, 40; `tick_1hz` and `sel_tick` at 20 and 40 only; `blink` is 1 between edges 10 and 20.
- **Refresh** -> `tick_refresh` at edges 4, 8, 12, …, independent of `adj` and `pause` activity.
- **adj raised at edge 12** -> `adj_mode` becomes 1 at edge 20; `sel_tick` at 20 (old mode, phase=1) and at 30, 40, 50. Lowering `adj` at edge 52 -> `adj_mode`=0 at 60; `sel_tick` at 60 (old mode); no `sel_tick` at 70; next `sel_tick` at 80.
- **adj pulse high for edges 12–15 only** -> `adj_mode` stays 0; `sel_tick` only at 20 and 40.
- **pause high from edge 15 to 45** -> no `sel_tick` at 20 or 40; `tick_1hz` still at 20 and 40; next `sel_tick` at 60.
- **rst asserted asynchronously at edge 23.5, released at edge 30** -> all outputs 0 immediately; next `tick_2hz` 10 edges after release (edge 40), no stale partial-period tick; `adj_mode` 0 until the first tick.
